// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Bundle of the control, serial-line and received-word
//                signals of the oversampling UART receiver. The master
//                modport is the side that owns the line and timing (register
//                block / testbench); the slave modport is the receiver.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 EN;
    logic                 BTICK;
    logic                 RX;
    logic                 PARITY_EN;
    logic                 PARITY_ODD;
    logic [DATA_BITS-1:0] DATA;
    logic                 DATA_VALID;
    logic                 PARITY_ERR;
    logic                 FRAME_ERR;
    logic                 BUSY;

    modport master (
        output EN, BTICK, RX, PARITY_EN, PARITY_ODD,
        input  DATA, DATA_VALID, PARITY_ERR, FRAME_ERR, BUSY
    );

    modport slave (
        input  EN, BTICK, RX, PARITY_EN, PARITY_ODD,
        output DATA, DATA_VALID, PARITY_ERR, FRAME_ERR, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver. Detects the start edge on the
//                synchronized line, resolves every bit at its centre using the
//                OVERSAMPLE-rate BTICK, deserializes LSB first with optional
//                parity and one stop bit, and reports each word with a
//                one-cycle DATA_VALID pulse plus parity/framing flags.
//                Optional build macro UART_RX_MAJORITY_EN: bit decisions take
//                the 2-of-3 majority of the last three oversamples instead of
//                the single sample on the decision tick.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    uart_rx_if.slave  bus
);

    localparam int c_tick_w = $clog2(OVERSAMPLE);
    localparam int c_bit_w  = $clog2(DATA_BITS + 1);

    // Tick-counter values at which a bit is resolved: half a bit into the
    // start bit, then one full bit period for every following bit.
    localparam logic [c_tick_w-1:0] c_start_dec = c_tick_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_tick_w-1:0] c_bit_dec   = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0]  c_last_bit  = c_bit_w'(DATA_BITS - 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    logic                 r_sync1;
    logic                 r_sync2;      // synchronized line (rx_s)
    logic                 r_rx_prev;    // rx_s as of the previous BTICK
    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [c_tick_w-1:0]  r_tick_cnt;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_en;     // parity mode latched at start detect
    logic                 r_par_odd;
    logic                 r_par_calc;   // parity mismatch of the current frame
    logic [DATA_BITS-1:0] r_data;
    logic                 r_data_valid;
    logic                 r_par_err;
    logic                 r_frame_err;

    logic                 w_start_edge;
    logic                 w_decide;
    logic [c_tick_w-1:0]  w_dec_val;
    logic                 w_sample;

    // Two-flop synchronizer for the asynchronous line; idles high so reset
    // cannot fabricate a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.RX;
            r_sync2 <= r_sync1;
        end
    end

    // Line level at the previous oversample tick, used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_prev <= 1'b1;
        end else if (bus.BTICK) begin
            r_rx_prev <= r_sync2;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;   // [0] = rx_s at previous BTICK, [1] = two BTICKs ago

    // Oversample history feeding the 2-of-3 vote on the decision tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else if (bus.BTICK) begin
            r_hist <= {r_hist[0], r_sync2};
        end
    end

    assign w_sample = (r_hist[1] & r_hist[0]) |
                      (r_hist[1] & r_sync2)   |
                      (r_hist[0] & r_sync2);
`else
    assign w_sample = r_sync2;
`endif

    // A start is a high-to-low transition seen between two BTICKs; a line
    // that stays low never produces one.
    assign w_start_edge = bus.EN & bus.BTICK & r_rx_prev & ~r_sync2;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and bit-decision strobe.
    always_comb begin
        w_state_next = r_state;
        w_dec_val    = (r_state == c_st_start) ? c_start_dec : c_bit_dec;
        w_decide     = bus.BTICK && (r_state != c_st_idle) && (r_tick_cnt == w_dec_val);

        case (r_state)
            c_st_idle: begin
                if (w_start_edge) begin
                    w_state_next = c_st_start;
                end
            end
            c_st_start: begin
                if (w_decide) begin
                    // A high centre means the edge was a glitch.
                    w_state_next = w_sample ? c_st_idle : c_st_data;
                end
            end
            c_st_data: begin
                if (w_decide && (r_bit_cnt == c_last_bit)) begin
                    w_state_next = r_par_en ? c_st_parity : c_st_stop;
                end
            end
            c_st_parity: begin
                if (w_decide) begin
                    w_state_next = c_st_stop;
                end
            end
            c_st_stop: begin
                if (w_decide) begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase

        if (!bus.EN) begin
            w_state_next = c_st_idle;
        end
    end

    // Bit timing, deserialization and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_en     <= 1'b0;
            r_par_odd    <= 1'b0;
            r_par_calc   <= 1'b0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;

            if (!bus.EN) begin
                // Abandon any frame in flight; the last word stays visible.
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
            end else if (r_state == c_st_idle) begin
                if (w_start_edge) begin
                    r_tick_cnt <= '0;
                    r_par_en   <= bus.PARITY_EN;
                    r_par_odd  <= bus.PARITY_ODD;
                end
            end else if (bus.BTICK) begin
                if (w_decide) begin
                    r_tick_cnt <= '0;
                    case (r_state)
                        c_st_start: begin
                            r_bit_cnt <= '0;
                        end
                        c_st_data: begin
                            r_shift   <= {w_sample, r_shift[DATA_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
                        end
                        c_st_parity: begin
                            r_par_calc <= (^r_shift) ^ w_sample ^ r_par_odd;
                        end
                        c_st_stop: begin
                            r_data       <= r_shift;
                            r_frame_err  <= ~w_sample;
                            r_par_err    <= r_par_en & r_par_calc;
                            r_data_valid <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end else begin
                    r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
                end
            end
        end
    end

    assign bus.DATA       = r_data;
    assign bus.DATA_VALID = r_data_valid;
    assign bus.PARITY_ERR = r_par_err;
    assign bus.FRAME_ERR  = r_frame_err;
    assign bus.BUSY       = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Frames are serialized from
//                a bit list at the oversample rate; expected words, flags and
//                the start-to-valid latency come from the frame format rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;
    localparam int OS = 16;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if #(.DATA_BITS(DB)) bus();

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ticks    = 0;
    int tick_div = 4;
    int busy_cnt = 0;
    logic prev_valid = 1'b0;
    int exp_detect;
    logic [DB-1:0] last_data;

    typedef struct {
        int            tick;
        logic [DB-1:0] data;
        logic          pe;
        logic          fe;
        logic          busy;
        logic          prev_valid;
    } ev_t;
    ev_t evq[$];

    typedef struct {
        logic [DB-1:0] data;
        logic          pe;
        logic          po;
        logic          pbit;
        logic          stop;
        logic [DB-1:0] x_data;
        logic          x_pe;
        logic          x_fe;
    } vec_t;

    // Free-running cycle and oversample-tick counters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.BTICK) ticks <= ticks + 1;
    end

    // Oversample tick generator, one pulse every tick_div clocks.
    initial begin
        int d;
        d = 0;
        bus.BTICK = 1'b0;
        forever begin
            @(negedge clk);
            d++;
            if (d >= tick_div) begin
                d = 0;
                bus.BTICK = 1'b1;
            end else begin
                bus.BTICK = 1'b0;
            end
        end
    end

    // Output monitor: records every DATA_VALID pulse.
    always @(negedge clk) begin
        if (bus.DATA_VALID) begin
            evq.push_back('{ticks, bus.DATA, bus.PARITY_ERR, bus.FRAME_ERR,
                            bus.BUSY, prev_valid});
        end
        prev_valid <= bus.DATA_VALID;
        busy_cnt   <= busy_cnt + (bus.BUSY ? 1 : 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int t0;
        t0 = ticks;
        while (ticks - t0 < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serialize one frame. g_lo/g_hi: clock window (relative to the start
    // drive) where the line is forced low. abort_mode 1 drops EN, 2 pulses
    // rst, at oversample tick abort_tk of the frame.
    task automatic send_frame(input logic [DB-1:0] data, input logic pe, input logic po,
                              input logic pbit, input logic stop, input logic after_level,
                              input int g_lo, input int g_hi,
                              input int abort_tk, input int abort_mode);
        logic bits[$];
        int   n0, t0, j, tk, prev_t, nb;
        bit   detected;
        bus.RX = 1'b1;
        wait_ticks(4);
        bus.PARITY_EN  = pe;
        bus.PARITY_ODD = po;
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(data[i]);
        if (pe) bits.push_back(pbit);
        bits.push_back(stop);
        nb = bits.size();
        exp_detect = -100000;
        detected = 0;
        n0 = cyc;
        t0 = ticks;
        prev_t = ticks;
        tk = 0;
        bus.RX = 1'b0;
        while (tk < nb * OS) begin
            @(posedge clk);
            #1;
            j  = cyc - n0;
            tk = ticks - t0;
            // rx_s reflects the line 3 edges later; the first tick from then on detects.
            if (!detected && ticks != prev_t && j >= 3) begin
                detected   = 1;
                exp_detect = ticks;
                bus.PARITY_EN  = ~pe;   // mode must be held from start detect
                bus.PARITY_ODD = ~po;
            end
            if (abort_mode != 0 && tk == abort_tk && ticks != prev_t) begin
                check("busy_before_abort", bus.BUSY, 1);
                if (abort_mode == 1) bus.EN = 1'b0;
                else                 rst    = 1'b1;
                @(posedge clk);
                #1;
                check("busy_after_abort", bus.BUSY, 0);
                check("valid_after_abort", bus.DATA_VALID, 0);
                if (abort_mode == 2) begin
                    check("rst_data", bus.DATA, 0);
                    check("rst_perr", bus.PARITY_ERR, 0);
                    check("rst_ferr", bus.FRAME_ERR, 0);
                end
                bus.RX = 1'b1;
                wait_ticks(4);
                bus.EN = 1'b1;
                rst    = 1'b0;
                return;
            end
            prev_t = ticks;
            if (tk < nb * OS) begin
                bus.RX = (j >= g_lo && j < g_hi) ? 1'b0 : bits[tk / OS];
            end
        end
        bus.RX = after_level;
    endtask

    task automatic check_word(input string name, input vec_t v);
        ev_t e;
        int  lat;
        wait_ticks(2);
        check({name, "_valid_count"}, evq.size(), 1);
        if (evq.size() > 0) begin
            e   = evq.pop_front();
            lat = OS / 2 + (DB + 1 + (v.pe ? 1 : 0)) * OS;
            check({name, "_data"}, e.data, v.x_data);
            check({name, "_perr"}, e.pe, v.x_pe);
            check({name, "_ferr"}, e.fe, v.x_fe);
            check({name, "_latency"}, e.tick - exp_detect, lat);
            check({name, "_busy_at_valid"}, e.busy, 0);
            check({name, "_pulse_width"}, e.prev_valid, 0);
        end
        evq.delete();
        last_data = v.x_data;
    endtask

    task automatic run_vec(input string name, input vec_t v, input int g_lo, input int g_hi);
        send_frame(v.data, v.pe, v.po, v.pbit, v.stop, 1'b1, g_lo, g_hi, 0, 0);
        check_word(name, v);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t v;
        int   c0;

        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vec_t v;
        int   c0;

        //            data   pe    po    pbit  stop  x_data x_pe  x_fe
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[3] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[4] = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

        bus.EN = 1'b1;
        bus.RX = 1'b1;
        bus.PARITY_EN  = 1'b0;
        bus.PARITY_ODD = 1'b0;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset_data", bus.DATA, 0);
        check("reset_valid", bus.DATA_VALID, 0);
        check("reset_perr", bus.PARITY_ERR, 0);
        check("reset_ferr", bus.FRAME_ERR, 0);
        check("reset_busy", bus.BUSY, 0);
        rst = 1'b0;
        last_data = '0;

        // Table of directed frames.
        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i], 0, 0);
        end

        // Framing error, then line held low: no re-arm until it rises again.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        check_word("ferr_3c", '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1});
        wait_ticks(48);
        check("held_low_no_valid", evq.size(), 0);
        check("held_low_not_busy", bus.BUSY, 0);
        run_vec("after_low_5a", '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0}, 0, 0);

        // Short low glitch: false start, no word.
        c0 = busy_cnt;
        bus.RX = 1'b0;
        wait_ticks(3);
        bus.RX = 1'b1;
        wait_ticks(24);
        check("glitch_busy_pulsed", (busy_cnt != c0), 1);
        check("glitch_no_valid", evq.size(), 0);
        check("glitch_idle", bus.BUSY, 0);
        check("glitch_data_held", bus.DATA, last_data);

        // One-tick low glitch on the decision tick of data bit 0 of 0xFF.
        v = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
`ifndef UART_RX_MAJORITY_EN
        v.x_data = 8'hFE;
`endif
        run_vec("bit0_glitch", v, 94, 98);

        // EN dropped during data bit 4.
        send_frame(8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 5 * OS + OS / 2, 1);
        wait_ticks(OS * 10);
        check("en_abort_no_valid", evq.size(), 0);
        check("en_abort_data_held", bus.DATA, last_data);
        evq.delete();
        run_vec("after_en_5a", '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0}, 0, 0);

        // Reset during data bit 4.
        send_frame(8'h66, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 5 * OS + OS / 2, 2);
        wait_ticks(OS * 10);
        check("rst_abort_no_valid", evq.size(), 0);
        evq.delete();
        run_vec("after_rst_5a", '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0}, 0, 0);

        // Random frames at varied tick rates (including back-to-back ticks).
        for (int i = 0; i < 24; i++) begin
            tick_div = $urandom_range(1, 4);
            v.data = DB'($urandom);
            v.pe   = 1'($urandom);
            v.po   = 1'($urandom);
            v.pbit = 1'($urandom);
            v.stop = ($urandom_range(0, 3) != 0);
            v.x_data = v.data;
            v.x_pe   = v.pe ? 1'(((($countones(v.data) + v.pbit) % 2) != v.po)) : 1'b0;
            v.x_fe   = ~v.stop;
            run_vec($sformatf("rand%0d", i), v, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
